// File: rtl/cv32e40s_write_buffer_fifo.sv
// DEPTH-entry in-order write buffer between LSU and OBI data port; 0-cycle bypass when empty, >=1 cycle when buffered.
// ready_o drops when full (unless the head pops) and for non-bufferable requests until the buffer has drained.
package cv32e40s_wbf_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [5:0]  atop;
        logic [1:0]  memtype;
        logic [2:0]  prot;
        logic        dbg;
    } obi_data_req_t;

    typedef struct packed {
        logic [33:0] word_addr_low;
        logic [33:0] word_addr_high;
        logic        main;
        logic        bufferable;
        logic        cacheable;
        logic        integrity;
    } pma_cfg_t;

    parameter pma_cfg_t PMA_R_DEFAULT = '{default: '0};
endpackage

module cv32e40s_write_buffer_fifo
    import cv32e40s_wbf_pkg::*;
#(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned PMA_NUM_REGIONS = 0,
    parameter pma_cfg_t    PMA_CFG [PMA_NUM_REGIONS-1:0] = '{default: PMA_R_DEFAULT}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_i,
    input  obi_data_req_t              trans_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output obi_data_req_t              trans_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    if (DEPTH < 1 || DEPTH > 8) begin : gen_bad_depth
        $error("cv32e40s_write_buffer_fifo: DEPTH must be in 1..8");
    end
    if ($bits(PMA_CFG) == 0 || PMA_NUM_REGIONS > 16) begin : gen_bad_pma
        $error("cv32e40s_write_buffer_fifo: illegal PMA configuration");
    end

    obi_data_req_t fifo_q [DEPTH];
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] wptr_q;
    logic [CW-1:0] cnt_q;
    logic          bufferable;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    // Non-power-of-two depths need an explicit wrap.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign bufferable = trans_i.memtype[0];
    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == CW'(DEPTH));

    // Non-bufferable requests wait for drain so they never overtake buffered writes.
    always_comb begin
        ready_o = bufferable;
        if (empty) begin
            ready_o = bufferable || ready_i;
        end else if (full) begin
            ready_o = bufferable && ready_i;
        end
    end

    assign push    = valid_i && bufferable && ready_o && !(empty && ready_i);
    assign pop     = !empty && ready_i;

    assign valid_o = !empty || valid_i;
    assign trans_o = empty ? trans_i : fifo_q[rptr_q];
    assign count_o = cnt_q;
    assign empty_o = empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= trans_i;
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
endmodule

// File: tb/tb_cv32e40s_write_buffer_fifo.sv
// Bench for the write buffer: directed scenarios on DEPTH=2, randomized wrap/order run on DEPTH=3, queue model.
module tb_cv32e40s_write_buffer_fifo;
    import cv32e40s_wbf_pkg::*;

    logic clk;
    logic rst_n;

    logic          v2, r2, rdy2, vo2, emp2;
    obi_data_req_t t2, to2;
    logic [1:0]    cnt2;

    logic          v3, r3, rdy3, vo3, emp3;
    obi_data_req_t t3, to3;
    logic [1:0]    cnt3;

    int n_vec;
    int n_err;

    obi_data_req_t q2[$];
    obi_data_req_t q3[$];
    obi_data_req_t ord3[$];

    cv32e40s_write_buffer_fifo #(.DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .valid_i(v2), .trans_i(t2), .ready_o(rdy2),
        .valid_o(vo2), .trans_o(to2), .ready_i(r2), .count_o(cnt2), .empty_o(emp2)
    );

    cv32e40s_write_buffer_fifo #(.DEPTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .valid_i(v3), .trans_i(t3), .ready_o(rdy3),
        .valid_o(vo3), .trans_o(to3), .ready_i(r3), .count_o(cnt3), .empty_o(emp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obi_data_req_t mk(input logic b);
        obi_data_req_t t;
        t.addr    = $urandom;
        t.we      = 1'b1;
        t.be      = 4'($urandom);
        t.wdata   = $urandom;
        t.atop    = '0;
        t.memtype = {1'($urandom), b};
        t.prot    = 3'($urandom);
        t.dbg     = 1'b0;
        return t;
    endfunction

    // Acceptance rule seen from upstream, given current occupancy.
    function automatic logic exp_rdy(input int n, input int depth, input logic b, input logic r);
        if (n == 0)     return b || r;
        if (n < depth)  return b;
        return b && r;
    endfunction

    // Advance the DEPTH=2 model across one clock edge; returns at the next negedge.
    task automatic tick2();
        logic b, acc, pop, push;
        b    = t2.memtype[0];
        acc  = v2 && exp_rdy(q2.size(), 2, b, r2);
        pop  = (q2.size() > 0) && r2;
        push = acc && b && !(q2.size() == 0 && r2);
        @(posedge clk);
        if (pop) void'(q2.pop_front());
        if (push) q2.push_back(t2);
        @(negedge clk);
    endtask

    task automatic test_reset();
        obi_data_req_t a;
        rst_n = 1'b0;
        a = mk(1'b1);
        v2 = 1'b1; t2 = a; r2 = 1'b0;
        v3 = 1'b0; t3 = '0; r3 = 1'b0;
        #1;
        n_vec++; if (cnt2 !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", cnt2); end
        n_vec++; if (emp2 !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b exp 1", emp2); end
        n_vec++; if (vo2 !== 1'b1 || to2 !== a) begin n_err++; $display("FAIL reset_passthru: valid %b trans %h exp 1 %h", vo2, to2, a); end
        n_vec++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", rdy2); end
        @(negedge clk);
        rst_n = 1'b1;
        v2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        obi_data_req_t a;
        a = mk(1'b1);
        v2 = 1'b1; t2 = a; r2 = 1'b1; #1;
        n_vec++; if (vo2 !== 1'b1 || to2 !== a) begin n_err++; $display("FAIL bypass_out: valid %b trans %h exp 1 %h", vo2, to2, a); end
        n_vec++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL bypass_ready: got %b exp 1", rdy2); end
        tick2();
        v2 = 1'b0; #1;
        n_vec++; if (cnt2 !== 2'd0 || emp2 !== 1'b1) begin n_err++; $display("FAIL bypass_count: count %0d empty %b exp 0 1", cnt2, emp2); end
    endtask

    task automatic test_fill_and_full();
        obi_data_req_t a, b, c;
        a = mk(1'b1); b = mk(1'b1); c = mk(1'b1);
        v2 = 1'b1; t2 = a; r2 = 1'b0; #1;
        n_vec++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL fill_a_ready: got %b exp 1", rdy2); end
        tick2();
        t2 = b; #1;
        n_vec++; if (cnt2 !== 2'd1 || rdy2 !== 1'b1 || to2 !== a) begin n_err++; $display("FAIL fill_b: count %0d ready %b trans %h exp 1 1 %h", cnt2, rdy2, to2, a); end
        tick2();
        t2 = c; #1;
        n_vec++; if (cnt2 !== 2'd2 || rdy2 !== 1'b0) begin n_err++; $display("FAIL fill_c_blocked: count %0d ready %b exp 2 0", cnt2, rdy2); end
        n_vec++; if (vo2 !== 1'b1 || to2 !== a) begin n_err++; $display("FAIL fill_head_stable: valid %b trans %h exp 1 %h", vo2, to2, a); end
        tick2();
        #1;
        n_vec++; if (cnt2 !== 2'd2 || to2 !== a) begin n_err++; $display("FAIL fill_hold: count %0d trans %h exp 2 %h", cnt2, to2, a); end
        // Full with downstream ready: same-cycle pop of A and push of C.
        r2 = 1'b1; #1;
        n_vec++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL full_pushpop_ready: got %b exp 1", rdy2); end
        tick2();
        v2 = 1'b0; #1;
        n_vec++; if (cnt2 !== 2'd2 || to2 !== b) begin n_err++; $display("FAIL full_pushpop: count %0d trans %h exp 2 %h", cnt2, to2, b); end
        tick2();
        #1;
        n_vec++; if (cnt2 !== 2'(q2.size()) || to2 !== q2[0] || to2 !== c) begin n_err++; $display("FAIL drain_c: count %0d trans %h exp 1 %h", cnt2, to2, c); end
        tick2();
        #1;
        n_vec++; if (emp2 !== 1'b1 || q2.size() != 0) begin n_err++; $display("FAIL drain_empty: got %b exp 1", emp2); end
    endtask

    task automatic test_nonbuf_order();
        obi_data_req_t a, l;
        a = mk(1'b1); l = mk(1'b0); l.we = 1'b0;
        v2 = 1'b1; t2 = a; r2 = 1'b0; #1;
        tick2();
        t2 = l; r2 = 1'b1; #1;
        n_vec++; if (rdy2 !== 1'b0 || to2 !== a) begin n_err++; $display("FAIL nonbuf_wait: ready %b trans %h exp 0 %h", rdy2, to2, a); end
        tick2();
        #1;
        n_vec++; if (rdy2 !== 1'b1 || to2 !== l || emp2 !== 1'b1) begin n_err++; $display("FAIL nonbuf_pass: ready %b trans %h empty %b exp 1 %h 1", rdy2, to2, emp2, l); end
        tick2();
        v2 = 1'b0;
    endtask

    task automatic cycle3(input logic v, input obi_data_req_t t, input logic r);
        int n;
        logic b, er, ev, acc, push;
        obi_data_req_t et;
        v3 = v; t3 = t; r3 = r; #1;
        n  = q3.size();
        b  = t.memtype[0];
        er = exp_rdy(n, 3, b, r);
        ev = (n > 0) || v;
        et = (n > 0) ? q3[0] : t;
        acc  = v && er;
        push = acc && b && !(n == 0 && r);
        if (acc) ord3.push_back(t);
        n_vec++; if (rdy3 !== er || vo3 !== ev) begin n_err++; $display("FAIL wrap_handshake: ready %b valid %b exp %b %b", rdy3, vo3, er, ev); end
        n_vec++; if (cnt3 !== 2'(n) || emp3 !== (n == 0)) begin n_err++; $display("FAIL wrap_count: count %0d empty %b exp %0d", cnt3, emp3, n); end
        if (ev) begin
            n_vec++; if (to3 !== et) begin n_err++; $display("FAIL wrap_trans: got %h exp %h", to3, et); end
        end
        if (ev && r) begin
            n_vec++;
            if (ord3.size() == 0) begin
                n_err++; $display("FAIL wrap_order: got %h exp none", to3);
            end else begin
                et = ord3.pop_front();
                if (to3 !== et) begin n_err++; $display("FAIL wrap_order: got %h exp %h", to3, et); end
            end
        end
        @(posedge clk);
        if (n > 0 && r) void'(q3.pop_front());
        if (push) q3.push_back(t);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 120; i++) begin
            cycle3($urandom_range(0, 3) != 0, mk($urandom_range(0, 4) != 0), 1'($urandom));
        end
        for (int i = 0; i < 5; i++) begin
            cycle3(1'b0, mk(1'b1), 1'b1);
        end
        n_vec++; if (ord3.size() != 0 || cnt3 !== 2'd0) begin n_err++; $display("FAIL wrap_drained: pending %0d count %0d exp 0 0", ord3.size(), cnt3); end
        v3 = 1'b0; r3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        obi_data_req_t a;
        v2 = 1'b1; r2 = 1'b0;
        t2 = mk(1'b1); #1; tick2();
        t2 = mk(1'b1); #1; tick2();
        v2 = 1'b0; #1;
        n_vec++; if (cnt2 !== 2'd2) begin n_err++; $display("FAIL rst_pre_count: got %0d exp 2", cnt2); end
        #1 rst_n = 1'b0;
        #1;
        q2.delete(); q3.delete(); ord3.delete();
        n_vec++; if (cnt2 !== 2'd0 || emp2 !== 1'b1) begin n_err++; $display("FAIL rst_mid: count %0d empty %b exp 0 1", cnt2, emp2); end
        @(negedge clk);
        rst_n = 1'b1;
        a = mk(1'b1);
        v2 = 1'b1; t2 = a; r2 = 1'b1; #1;
        n_vec++; if (rdy2 !== 1'b1 || vo2 !== 1'b1 || to2 !== a) begin n_err++; $display("FAIL rst_bypass: ready %b valid %b trans %h exp 1 1 %h", rdy2, vo2, to2, a); end
        tick2();
        v2 = 1'b0; #1;
        n_vec++; if (cnt2 !== 2'd0 || emp2 !== 1'b1) begin n_err++; $display("FAIL rst_bypass_count: count %0d empty %b exp 0 1", cnt2, emp2); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_bypass();
        test_fill_and_full();
        test_nonbuf_order();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
